// File: rtl/sift_pkg.sv
// Shared types and helpers for the gradient pyramid scheduler.
package sift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    RUN
  } sched_state_t;

  localparam int MASK_MAX_W = 32;

  // Index of the least significant set bit; returns 0 for an all-zero mask.
  function automatic logic [4:0] lowest_set_bit(input logic [MASK_MAX_W-1:0] mask);
    logic [4:0] idx;
    idx = '0;
    for (int i = MASK_MAX_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/read_port_arbiter.sv
// Fixed-priority sharing of the source BRAM read port between the gradient
// engine and an auxiliary requester, plus the aux read-data valid pipeline.
module read_port_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eng_valid,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_valid,
  output logic              aux_grant,
  output logic              aux_rdata_valid
);

  // Aux handshake: the requester raises aux_req with aux_addr and holds both
  // stable until a cycle where aux_grant is high; that cycle is the transfer,
  // and its data appears on the shared bus two cycles later (aux_rdata_valid).
  // The engine never waits: any engine strobe takes the port that cycle.
  always_comb begin
    bram_addr  = '0;
    bram_valid = 1'b0;
    aux_grant  = 1'b0;
    if (eng_valid) begin
      bram_addr  = eng_addr;
      bram_valid = 1'b1;
    end else if (aux_req) begin
      bram_addr  = aux_addr;
      bram_valid = 1'b1;
      aux_grant  = 1'b1;
    end
  end

  logic [1:0] aux_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      aux_pipe <= '0;
    end else begin
      aux_pipe <= {aux_pipe[0], aux_grant};
    end
  end

  assign aux_rdata_valid = aux_pipe[1];

endmodule

// File: rtl/gradient_level_scheduler.sv
// Runs one gradient engine over each selected pyramid level in ascending order,
// remapping the engine's per-image addresses into that level's BRAM region.
module gradient_level_scheduler
  import sift_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int BIT_DEPTH  = 8,
  parameter int NUM_LEVELS = 4,
  localparam int PIX_W  = $clog2(WIDTH * HEIGHT),
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT * NUM_LEVELS),
  localparam int LVL_W  = $clog2(NUM_LEVELS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [NUM_LEVELS-1:0] level_mask_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [LVL_W-1:0]      level_out,
  output logic                  grad_start_out,
  input  logic                  grad_done_in,
  input  logic [PIX_W-1:0]      grad_read_addr_in,
  input  logic                  grad_read_valid_in,
  input  logic [PIX_W-1:0]      grad_x_write_addr_in,
  input  logic [PIX_W-1:0]      grad_y_write_addr_in,
  input  logic                  grad_x_write_valid_in,
  input  logic                  grad_y_write_valid_in,
  output logic [ADDR_W-1:0]     bram_read_addr,
  output logic                  bram_read_valid,
  output logic [ADDR_W-1:0]     x_write_addr,
  output logic [ADDR_W-1:0]     y_write_addr,
  output logic                  x_write_valid,
  output logic                  y_write_valid,
  input  logic                  aux_read_req_in,
  input  logic [ADDR_W-1:0]     aux_read_addr_in,
  output logic                  aux_read_grant_out,
  output logic                  aux_rdata_valid_out,
  output sched_state_t          fsm_state
);

  if (NUM_LEVELS < 2 || NUM_LEVELS > MASK_MAX_W || BIT_DEPTH < 1) begin : g_bad_params
    $error("gradient_level_scheduler: NUM_LEVELS must be 2..32 and BIT_DEPTH >= 1");
  end

  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(WIDTH * HEIGHT);

  sched_state_t          state;
  logic [NUM_LEVELS-1:0] pending;
  logic                  ran_any;
  logic [ADDR_W-1:0]     off;

  assign fsm_state = state;

  // ran_any separates an empty run (busy drops with done) from a real run
  // (busy stays up through the done cycle).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pending        <= '0;
      ran_any        <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      level_out      <= '0;
      grad_start_out <= 1'b0;
    end else begin
      done_out       <= 1'b0;
      grad_start_out <= 1'b0;
      case (state)
        IDLE: begin
          busy_out <= 1'b0;
          if (start_in) begin
            pending  <= level_mask_in;
            ran_any  <= 1'b0;
            busy_out <= 1'b1;
            state    <= SELECT;
          end
        end
        SELECT: begin
          if (pending != '0) begin
            level_out      <= LVL_W'(lowest_set_bit(MASK_MAX_W'(pending)));
            grad_start_out <= 1'b1;
            ran_any        <= 1'b1;
            state          <= RUN;
          end else begin
            done_out <= 1'b1;
            busy_out <= ran_any;
            state    <= IDLE;
          end
        end
        RUN: begin
          if (grad_done_in) begin
            pending <= pending & ~(NUM_LEVELS'(1) << level_out);
            state   <= SELECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign off           = ADDR_W'(level_out) * FRAME;
  assign x_write_addr  = off + ADDR_W'(grad_x_write_addr_in);
  assign y_write_addr  = off + ADDR_W'(grad_y_write_addr_in);
  assign x_write_valid = grad_x_write_valid_in;
  assign y_write_valid = grad_y_write_valid_in;

  read_port_arbiter #(
    .ADDR_W(ADDR_W)
  ) u_read_port_arbiter (
    .clk            (clk_in),
    .rst            (rst_in),
    .eng_valid      (grad_read_valid_in),
    .eng_addr       (off + ADDR_W'(grad_read_addr_in)),
    .aux_req        (aux_read_req_in),
    .aux_addr       (aux_read_addr_in),
    .bram_addr      (bram_read_addr),
    .bram_valid     (bram_read_valid),
    .aux_grant      (aux_read_grant_out),
    .aux_rdata_valid(aux_rdata_valid_out)
  );

endmodule

// File: tb/tb_gradient_level_scheduler.sv
// Scoreboard bench for gradient_level_scheduler with a 10-cycle engine model
// and a held-request auxiliary reader.
module tb_gradient_level_scheduler;
  import sift_pkg::*;

  localparam int WIDTH      = 64;
  localparam int HEIGHT     = 64;
  localparam int NUM_LEVELS = 4;
  localparam int FRAME      = WIDTH * HEIGHT;
  localparam int PIX_W      = 12;
  localparam int ADDR_W     = 14;
  localparam int LVL_W      = 2;
  localparam int RUN_LEN    = 10;
  localparam int BIG        = 1 << 30;

  logic                  clk = 1'b0;
  logic                  rst_in;
  logic                  start_in;
  logic [NUM_LEVELS-1:0] level_mask_in;
  logic                  busy_out, done_out, grad_start_out;
  logic [LVL_W-1:0]      level_out;
  logic                  grad_done_in;
  logic [PIX_W-1:0]      grad_read_addr_in, grad_x_write_addr_in, grad_y_write_addr_in;
  logic                  grad_read_valid_in, grad_x_write_valid_in, grad_y_write_valid_in;
  logic [ADDR_W-1:0]     bram_read_addr, x_write_addr, y_write_addr;
  logic                  bram_read_valid, x_write_valid, y_write_valid;
  logic                  aux_read_req_in;
  logic [ADDR_W-1:0]     aux_read_addr_in;
  logic                  aux_read_grant_out, aux_rdata_valid_out;
  sched_state_t          fsm_state;

  gradient_level_scheduler dut (
    .clk_in               (clk),
    .rst_in               (rst_in),
    .start_in             (start_in),
    .level_mask_in        (level_mask_in),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .level_out            (level_out),
    .grad_start_out       (grad_start_out),
    .grad_done_in         (grad_done_in),
    .grad_read_addr_in    (grad_read_addr_in),
    .grad_read_valid_in   (grad_read_valid_in),
    .grad_x_write_addr_in (grad_x_write_addr_in),
    .grad_y_write_addr_in (grad_y_write_addr_in),
    .grad_x_write_valid_in(grad_x_write_valid_in),
    .grad_y_write_valid_in(grad_y_write_valid_in),
    .bram_read_addr       (bram_read_addr),
    .bram_read_valid      (bram_read_valid),
    .x_write_addr         (x_write_addr),
    .y_write_addr         (y_write_addr),
    .x_write_valid        (x_write_valid),
    .y_write_valid        (y_write_valid),
    .aux_read_req_in      (aux_read_req_in),
    .aux_read_addr_in     (aux_read_addr_in),
    .aux_read_grant_out   (aux_read_grant_out),
    .aux_rdata_valid_out  (aux_rdata_valid_out),
    .fsm_state            (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit is_done;
    int level;
    int at;
  } ev_t;

  ev_t               ev_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  bit                rd_grant_q[$];
  logic [ADDR_W-1:0] x_q[$];
  logic [ADDR_W-1:0] y_q[$];
  int                aux_q[$];
  int                lvl_list[$];

  int  cur_level = 0;
  int  busy_from = BIG;
  int  busy_until = -1;
  bit  mon_en = 1'b0;
  bit  done_seen = 1'b0;
  int  aux_left = 0;
  bit  aux_active = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  int  rd_mode = 0;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- engine + aux drivers with reference model ----------------
  initial begin : engine_model
    int  left;
    int  step;
    bit  seen;
    left = 0;
    step = 0;
    grad_done_in = 1'b0;
    grad_read_valid_in = 1'b0;
    grad_x_write_valid_in = 1'b0;
    grad_y_write_valid_in = 1'b0;
    grad_read_addr_in = '0;
    grad_x_write_addr_in = '0;
    grad_y_write_addr_in = '0;
    aux_read_req_in = 1'b0;
    aux_read_addr_in = '0;
    forever begin
      @(negedge clk);
      seen = grad_start_out && !rst_in;
      if (rst_in) left = 0;
      @(posedge clk);
      #1;
      grad_done_in = 1'b0;
      grad_read_valid_in = 1'b0;
      grad_x_write_valid_in = 1'b0;
      grad_y_write_valid_in = 1'b0;
      if (seen) begin
        left = RUN_LEN;
        step = 0;
        cur_level = (lvl_list.size() > 0) ? lvl_list[0] : 0;
      end
      if (left > 0) begin
        left--;
        step++;
        if (left == 0) begin
          ev_t e;
          grad_done_in = 1'b1;
          if (lvl_list.size() > 0) void'(lvl_list.pop_front());
          if (lvl_list.size() == 0) begin
            e = '{is_done: 1'b1, level: 0, at: cyc + 2};
            busy_until = cyc + 2;
          end else begin
            e = '{is_done: 1'b0, level: lvl_list[0], at: cyc + 2};
          end
          ev_q.push_back(e);
        end else begin
          grad_read_addr_in = PIX_W'($urandom_range(0, FRAME - 1));
          if (rd_mode == 1) begin
            grad_read_valid_in = (cyc % 3 == 0);
          end else if (step == 1) begin
            grad_read_valid_in = 1'b1;
            grad_read_addr_in = PIX_W'(5);
          end else begin
            grad_read_valid_in = 1'($urandom_range(0, 1));
          end
          grad_x_write_valid_in = 1'($urandom_range(0, 1));
          grad_y_write_valid_in = 1'($urandom_range(0, 1));
          grad_x_write_addr_in = PIX_W'($urandom_range(0, FRAME - 1));
          grad_y_write_addr_in = PIX_W'($urandom_range(0, FRAME - 1));
        end
      end
      if (!aux_active && aux_left > 0 && $urandom_range(0, 2) == 0) begin
        aux_active = 1'b1;
        aux_addr = ADDR_W'($urandom_range(0, FRAME * NUM_LEVELS - 1));
      end
      aux_read_req_in = aux_active;
      aux_read_addr_in = aux_addr;
      // reference: engine owns the read port whenever it strobes
      if (grad_read_valid_in) begin
        rd_addr_q.push_back(ADDR_W'(cur_level * FRAME + int'(grad_read_addr_in)));
        rd_grant_q.push_back(1'b0);
      end else if (aux_active) begin
        rd_addr_q.push_back(aux_addr);
        rd_grant_q.push_back(1'b1);
        aux_q.push_back(cyc + 2);
        aux_active = 1'b0;
        aux_left--;
      end
      if (grad_x_write_valid_in) x_q.push_back(ADDR_W'(cur_level * FRAME + int'(grad_x_write_addr_in)));
      if (grad_y_write_valid_in) y_q.push_back(ADDR_W'(cur_level * FRAME + int'(grad_y_write_addr_in)));
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    ev_t               e;
    logic [ADDR_W-1:0] a;
    bit                g;
    bit                exp_busy;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      exp_busy = (cyc >= busy_from) && (cyc <= busy_until);
      chk(busy_out == exp_busy, "busy", busy_out, exp_busy);
      while (ev_q.size() > 0 && ev_q[0].at < cyc) begin
        chk(1'b0, "event_missing", cyc, ev_q[0].at);
        void'(ev_q.pop_front());
      end
      if (done_out) done_seen = 1'b1;
      if (grad_start_out || done_out) begin
        if (ev_q.size() == 0) begin
          chk(1'b0, "event_unexpected", {grad_start_out, done_out}, 0);
        end else begin
          e = ev_q.pop_front();
          chk(done_out == e.is_done && grad_start_out == !e.is_done, "event_kind",
              {grad_start_out, done_out}, e.is_done ? 1 : 2);
          chk(cyc == e.at, "event_cycle", cyc, e.at);
          if (!e.is_done) chk(level_out == LVL_W'(e.level), "start_level", level_out, e.level);
        end
      end
      if (bram_read_valid) begin
        if (rd_addr_q.size() == 0) begin
          chk(1'b0, "read_unexpected", bram_read_addr, -1);
        end else begin
          a = rd_addr_q.pop_front();
          g = rd_grant_q.pop_front();
          chk(bram_read_addr == a, "read_addr", bram_read_addr, a);
          chk(aux_read_grant_out == g, "aux_grant", aux_read_grant_out, g);
        end
      end else begin
        if (aux_read_grant_out) chk(1'b0, "grant_without_read", aux_read_grant_out, 0);
        while (rd_addr_q.size() > 0) begin
          chk(1'b0, "read_missing", 0, rd_addr_q[0]);
          void'(rd_addr_q.pop_front());
          void'(rd_grant_q.pop_front());
        end
      end
      if (x_write_valid) begin
        if (x_q.size() == 0) chk(1'b0, "x_write_unexpected", x_write_addr, -1);
        else begin a = x_q.pop_front(); chk(x_write_addr == a, "x_write_addr", x_write_addr, a); end
      end else if (x_q.size() > 0) begin
        chk(1'b0, "x_write_missing", 0, x_q[0]);
        void'(x_q.pop_front());
      end
      if (y_write_valid) begin
        if (y_q.size() == 0) chk(1'b0, "y_write_unexpected", y_write_addr, -1);
        else begin a = y_q.pop_front(); chk(y_write_addr == a, "y_write_addr", y_write_addr, a); end
      end else if (y_q.size() > 0) begin
        chk(1'b0, "y_write_missing", 0, y_q[0]);
        void'(y_q.pop_front());
      end
      while (aux_q.size() > 0 && aux_q[0] < cyc) begin
        chk(1'b0, "aux_rdata_missing", cyc, aux_q[0]);
        void'(aux_q.pop_front());
      end
      if (aux_rdata_valid_out) begin
        if (aux_q.size() > 0 && aux_q[0] == cyc) begin
          chk(1'b1 == aux_rdata_valid_out, "aux_rdata_cycle", cyc, aux_q[0]);
          void'(aux_q.pop_front());
        end else begin
          chk(1'b0, "aux_rdata_unexpected", cyc, (aux_q.size() > 0) ? aux_q[0] : -1);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_run(input logic [NUM_LEVELS-1:0] m);
    ev_t e;
    @(posedge clk);
    #1;
    lvl_list.delete();
    for (int i = 0; i < NUM_LEVELS; i++) if (m[i]) lvl_list.push_back(i);
    if (lvl_list.size() == 0) begin
      e = '{is_done: 1'b1, level: 0, at: cyc + 2};
      busy_until = cyc + 1;
    end else begin
      e = '{is_done: 1'b0, level: lvl_list[0], at: cyc + 2};
      busy_until = BIG;
    end
    ev_q.push_back(e);
    busy_from = cyc + 1;
    done_seen = 1'b0;
    start_in = 1'b1;
    level_mask_in = m;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    level_mask_in = NUM_LEVELS'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(done_seen, "done_timeout", done_seen, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run_mask(input logic [NUM_LEVELS-1:0] m);
    start_run(m);
    wait_done();
  endtask

  task automatic wait_aux();
    int n;
    n = 0;
    while ((aux_left > 0 || aux_active || aux_q.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    rst_in = 1'b1;
    start_in = 1'b0;
    level_mask_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk(busy_out == 1'b0, "reset_busy", busy_out, 0);
    chk(done_out == 1'b0, "reset_done", done_out, 0);
    chk(level_out == '0, "reset_level", level_out, 0);
    chk(grad_start_out == 1'b0, "reset_grad_start", grad_start_out, 0);
    chk(aux_rdata_valid_out == 1'b0, "reset_aux_rdata_valid", aux_rdata_valid_out, 0);
    chk(fsm_state == IDLE, "reset_state", fsm_state, IDLE);
    mon_en = 1'b1;

    run_mask(4'b1111);
    run_mask(4'b1010);
    run_mask(4'b0000);

    rd_mode = 1;
    aux_left = 8;
    run_mask(4'b0011);
    wait_aux();
    rd_mode = 0;

    // start pulse while a level is running must be ignored
    start_run(4'b0101);
    repeat (4) @(posedge clk);
    #1;
    start_in = 1'b1;
    level_mask_in = 4'b1111;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    wait_done();

    // reset in the middle of level 2
    start_run(4'b0100);
    repeat (6) @(posedge clk);
    #1;
    rst_in = 1'b1;
    lvl_list.delete();
    busy_until = cyc;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    @(negedge clk);
    chk(busy_out == 1'b0, "abort_busy", busy_out, 0);
    chk(done_out == 1'b0, "abort_done", done_out, 0);
    chk(level_out == '0, "abort_level", level_out, 0);
    chk(grad_start_out == 1'b0, "abort_grad_start", grad_start_out, 0);
    chk(aux_rdata_valid_out == 1'b0, "abort_aux_rdata_valid", aux_rdata_valid_out, 0);
    chk(fsm_state == IDLE, "abort_state", fsm_state, IDLE);
    repeat (15) @(posedge clk);
    run_mask(4'b0001);

    repeat (6) begin
      aux_left = $urandom_range(0, 4);
      rd_mode = $urandom_range(0, 1);
      run_mask(NUM_LEVELS'($urandom_range(0, 15)));
    end
    wait_aux();
    repeat (4) @(posedge clk);
    @(negedge clk);

    chk(ev_q.size() == 0, "events_outstanding", ev_q.size(), 0);
    chk(aux_q.size() == 0, "aux_outstanding", aux_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gradient_level_scheduler.md
# gradient_level_scheduler

Sequences one `gradient_image` engine over up to `NUM_LEVELS` pyramid images. The images are stored back-to-back in a single source BRAM, and results go to back-to-back regions of the x/y gradient BRAMs. The block remaps the engine's per-image addresses into the current level's region. It also shares the source BRAM read port with an auxiliary requester (keypoint reader) on a fixed-priority basis.

## Interface
Parameters:
- `WIDTH`, 64: image width in pixels
- `HEIGHT`, 64: image height in pixels
- `BIT_DEPTH`, 8: pixel width
- `NUM_LEVELS`, 4: number of images in the stack

Local widths:
- `PIX_W` = $clog2(WIDTH*HEIGHT)
- `ADDR_W` = $clog2(WIDTH*HEIGHT*NUM_LEVELS)

Ports:
- `clk_in`  in  1  single clock
- `rst_in`  in  1  reset; synchronous, active-high
- `start_in`  in  1  one-cycle pulse that starts a run
- `level_mask_in`  in  NUM_LEVELS  levels to process; sampled with `start_in`
- `busy_out`  out  1  high from the cycle after an accepted start until `done_out`
- `done_out`  out  1  one-cycle pulse at end of run
- `level_out`  out  $clog2(NUM_LEVELS)  level currently being processed
- `grad_start_out`  out  1  one-cycle start pulse to the engine
- `grad_done_in`  in  1  engine done pulse
- `grad_read_addr_in`  in  PIX_W  engine read address
- `grad_read_valid_in`  in  1  engine read strobe
- `grad_x_write_addr_in`, `grad_y_write_addr_in`  in  PIX_W  engine write addresses
- `grad_x_write_valid_in`, `grad_y_write_valid_in`  in  1  engine write strobes
- `bram_read_addr`  out  ADDR_W  source BRAM address
- `bram_read_valid`  out  1  source BRAM read strobe
- `x_write_addr`, `y_write_addr`  out  ADDR_W  gradient BRAM addresses
- `x_write_valid`, `y_write_valid`  out  1  gradient BRAM write strobes
- `aux_read_req_in`  in  1  auxiliary read request
- `aux_read_addr_in`  in  ADDR_W  auxiliary absolute address
- `aux_read_grant_out`  out  1  request accepted this cycle
- `aux_rdata_valid_out`  out  1  BRAM data on the shared data bus belongs to aux

## Operation
- Gradient pixel data and source BRAM read data connect directly between the engine and the BRAMs. This block only remaps addresses and strobes.
- Level offset `OFF` = `level_out` * WIDTH*HEIGHT, computed at ADDR_W width with no truncation.
- Remapping:
  - `x_write_addr` = `OFF` + `grad_x_write_addr_in`, combinational.
  - `y_write_addr` = `OFF` + `grad_y_write_addr_in`, combinational.
  - `x_write_valid` = `grad_x_write_valid_in`; `y_write_valid` = `grad_y_write_valid_in`.
- Read port arbitration (combinational):
  - If `grad_read_valid_in` is high: `bram_read_addr` = `OFF` + `grad_read_addr_in`, `bram_read_valid` = 1, `aux_read_grant_out` = 0.
  - Otherwise, if `aux_read_req_in` is high: `bram_read_addr` = `aux_read_addr_in`, `bram_read_valid` = 1, `aux_read_grant_out` = 1.
  - Otherwise: `bram_read_valid` = 0.
  - The engine always wins. The aux requester holds its request until granted.
- FSM states: IDLE, SELECT, RUN.
  - IDLE: on `start_in`, latch `level_mask_in` into the pending mask, then go to SELECT. `start_in` in any other state is ignored.
  - SELECT, pending mask nonzero: set `level_out` to the lowest set bit, pulse `grad_start_out`, go to RUN.
  - SELECT, pending mask zero: pulse `done_out`, go to IDLE.
  - RUN: on `grad_done_in`, clear the current level's bit in the pending mask, go to SELECT. `grad_done_in` outside RUN is ignored.
- An all-zero mask completes with no engine activity.

## Timing
- All registered outputs reset to 0: `busy_out`, `done_out`, `level_out`, `grad_start_out`, `aux_rdata_valid_out`. The pending mask resets to 0 and the state to IDLE.
- Reset mid-run aborts with no `done_out`. The engine shares `rst_in`.
- Start sampled in cycle 0:
  - SELECT in cycle 1.
  - `grad_start_out` and the new `level_out` in cycle 2.
  - Empty mask: `done_out` in cycle 2.
- `grad_done_in` in cycle k:
  - Next `grad_start_out` in cycle k+2.
  - Or, after the last level, `done_out` in cycle k+2 and `busy_out` low in cycle k+3.
- `level_out` holds its value from `grad_start_out` until the next SELECT updates it. It stays stable for the engine's entire run, including its final writes.
- Address remapping adds zero latency, preserving the engine's 2-cycle read assumption.
- `aux_rdata_valid_out` is asserted exactly 2 cycles after `aux_read_grant_out`, implemented as a 2-stage shift register. Overlapping grants produce back-to-back valids.

## Structure
- Shared package `sift_pkg`:
  - `sched_state_t` enum {IDLE, SELECT, RUN}
  - a `lowest_set_bit` function
- Sub-module `read_port_arbiter`:
  - contains the combinational mux, the grant logic and the aux valid pipeline
- FSM and offset logic sit at the top level.

## Test plan
- Mask 4'b1111, 64x64 image, engine model with a 10-cycle run:
  - four `grad_start_out` pulses with `level_out` = 0, 1, 2, 3
  - `done_out` 2 cycles after the 4th `grad_done_in`
- Mask 4'b1010:
  - exactly two runs, at levels 1 and 3
  - `grad_read_addr_in` = 5 at level 3 drives `bram_read_addr` = 12293
- Mask 0:
  - `done_out` in cycle 2
  - `grad_start_out` never asserts
  - `busy_out` high only in cycle 1
- Aux request held while the engine strobes reads every 3rd cycle:
  - grants occur only in non-engine cycles
  - `aux_rdata_valid_out` exactly 2 cycles after each grant
  - no grant coincides with `grad_read_valid_in`
- `start_in` pulsed during RUN:
  - ignored; mask unchanged
- `rst_in` asserted mid-level-2 for 1 cycle:
  - all outputs 0 next cycle, no `done_out`
  - a new start with mask 4'b0001 runs normally at level 0
